// File: rtl/bp_perf_counter_mmio.sv
// Branch-predictor performance counters behind an 8-word MMIO window.
// Three saturating 32-bit counters with LO-read snapshot of the high half and registered 1-cycle reads.
module bp_perf_counter_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'hC000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mm_we,
  input  logic        mm_re,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt,
  output logic [15:0] rdata,
  output logic        rd_hit
);

  logic             en_q, en_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] mispr_cnt_q, mispr_cnt_d;
  logic [15:0]      br_shadow_q, br_shadow_d;
  logic [15:0]      hit_shadow_q, hit_shadow_d;
  logic [15:0]      mispr_shadow_q, mispr_shadow_d;
  logic [2:0]       sat_q, sat_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rd_hit_q, rd_hit_d;

  logic             sel;
  logic [2:0]       off;
  logic             ctrl_wr;
  logic             clr;
  logic             rd;
  logic [2:0]       inc;
  logic [15:0]      reg_val;
  logic [2:0][CNT_W-1:0] cur_cnt, nxt_cnt;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[15:2];

  assign sel     = (addr[15:3] == BASE_ADDR[15:3]);
  assign off     = addr[2:0];
  assign rd      = mm_re & sel;
  assign ctrl_wr = mm_we & sel & (off == 3'd0);
  assign clr     = ctrl_wr & wdata[1];
  assign inc     = {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} & {3{en_q}};
  assign cur_cnt = {mispr_cnt_q, hit_cnt_q, br_cnt_q};

  // Register view as seen before this edge's updates.
  always_comb begin
    reg_val = '0;
    case (off)
      3'd0: reg_val = {15'd0, en_q};
      3'd1: reg_val = br_cnt_q[15:0];
      3'd2: reg_val = br_shadow_q;
      3'd3: reg_val = hit_cnt_q[15:0];
      3'd4: reg_val = hit_shadow_q;
      3'd5: reg_val = mispr_cnt_q[15:0];
      3'd6: reg_val = mispr_shadow_q;
      3'd7: reg_val = {13'd0, sat_q};
      default: reg_val = '0;
    endcase
  end

  always_comb begin
    nxt_cnt = cur_cnt;
    sat_d   = sat_q;
    if (clr) begin
      nxt_cnt = '0;
      sat_d   = '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (inc[i]) begin
          if (cur_cnt[i] == '1) sat_d[i] = 1'b1;
          else                  nxt_cnt[i] = cur_cnt[i] + 1'b1;
        end
      end
    end
    br_cnt_d    = nxt_cnt[0];
    hit_cnt_d   = nxt_cnt[1];
    mispr_cnt_d = nxt_cnt[2];
  end

  always_comb begin
    en_d           = ctrl_wr ? wdata[0] : en_q;
    br_shadow_d    = br_shadow_q;
    hit_shadow_d   = hit_shadow_q;
    mispr_shadow_d = mispr_shadow_q;
    if (clr) begin
      br_shadow_d    = '0;
      hit_shadow_d   = '0;
      mispr_shadow_d = '0;
    end else if (rd) begin
      // LO read captures the pre-increment high half for a coherent HI read.
      if (off == 3'd1) br_shadow_d    = br_cnt_q[31:16];
      if (off == 3'd3) hit_shadow_d   = hit_cnt_q[31:16];
      if (off == 3'd5) mispr_shadow_d = mispr_cnt_q[31:16];
    end
    rdata_d  = rd ? reg_val : '0;
    rd_hit_d = rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q           <= 1'b0;
      br_cnt_q       <= '0;
      hit_cnt_q      <= '0;
      mispr_cnt_q    <= '0;
      br_shadow_q    <= '0;
      hit_shadow_q   <= '0;
      mispr_shadow_q <= '0;
      sat_q          <= '0;
      rdata_q        <= '0;
      rd_hit_q       <= 1'b0;
    end else begin
      en_q           <= en_d;
      br_cnt_q       <= br_cnt_d;
      hit_cnt_q      <= hit_cnt_d;
      mispr_cnt_q    <= mispr_cnt_d;
      br_shadow_q    <= br_shadow_d;
      hit_shadow_q   <= hit_shadow_d;
      mispr_shadow_q <= mispr_shadow_d;
      sat_q          <= sat_d;
      rdata_q        <= rdata_d;
      rd_hit_q       <= rd_hit_d;
    end
  end

  assign rdata  = rdata_q;
  assign rd_hit = rd_hit_q;

endmodule

// File: tb/tb_bp_perf_counter_mmio.sv
// Scoreboard bench for bp_perf_counter_mmio: driver pushes model read responses, monitor pops on each edge.
module tb_bp_perf_counter_mmio;

  localparam logic [15:0] BASE = 16'hC000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        mm_we = 1'b0;
  logic        mm_re = 1'b0;
  logic        inc_br_cnt = 1'b0;
  logic        inc_hit_cnt = 1'b0;
  logic        inc_mispr_cnt = 1'b0;
  logic [15:0] rdata;
  logic        rd_hit;

  bp_perf_counter_mmio #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mm_we(mm_we), .mm_re(mm_re),
    .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt),
    .rdata(rdata), .rd_hit(rd_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [15:0] data;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: counters as plain numbers, register map from the register descriptions.
  logic [31:0] m_cnt [3];
  logic [15:0] m_sh  [3];
  logic        m_sat [3];
  logic        m_en;
  logic [31:0] bd_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_sh[i] = 0; m_sat[i] = 1'b0;
    end
    m_en = 1'b0;
  endfunction

  function automatic logic [15:0] model_read(input int off);
    int k;
    if (off == 0) return {15'd0, m_en};
    if (off == 7) return {13'd0, m_sat[2], m_sat[1], m_sat[0]};
    k = (off - 1) / 2;
    if (off % 2 == 1) return m_cnt[k][15:0];
    return m_sh[k];
  endfunction

  // Apply one bus cycle to the model, using the values currently on the DUT inputs.
  function automatic void model_step();
    logic sel;
    int   off;
    logic en_old;
    logic clr;
    logic [2:0] inc;
    exp_t e;
    sel = (addr[15:3] == BASE[15:3]);
    off = int'(addr[2:0]);
    inc = {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt};
    if (mm_re) begin
      e.hit  = sel;
      e.data = sel ? model_read(off) : 16'h0000;
      e.name = $sformatf("read@%h", addr);
      exp_q.push_back(e);
      if (sel && (off % 2 == 1) && off != 7) m_sh[(off - 1) / 2] = m_cnt[(off - 1) / 2][31:16];
    end
    en_old = m_en;
    clr = mm_we && sel && off == 0 && wdata[1];
    if (mm_we && sel && off == 0) m_en = wdata[0];
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_sh[i] = 0; m_sat[i] = 1'b0;
      end
    end else if (en_old) begin
      for (int i = 0; i < 3; i++) begin
        if (inc[i]) begin
          if (m_cnt[i] == 32'hFFFF_FFFF) m_sat[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endfunction

  task automatic drive(input logic re, input logic we, input logic [15:0] a,
                       input logic [15:0] wd, input logic [2:0] inc);
    mm_re = re; mm_we = we; addr = a; wdata = wd;
    {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = inc;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [2:0] inc);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000, inc);
  endtask

  task automatic rd(input int off, input logic [2:0] inc);
    drive(1'b1, 1'b0, BASE + 16'(off), 16'h0000, inc);
  endtask

  task automatic wr_ctrl(input logic [15:0] wd, input logic [2:0] inc);
    drive(1'b0, 1'b1, BASE, wd, inc);
  endtask

  // Backdoor preload: the forced value is held across one edge so the flop captures it.
  task automatic set_cnt(input int idx, input logic [31:0] v);
    mm_re = 1'b0; mm_we = 1'b0;
    {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b000;
    bd_val = v;
    case (idx)
      0: force dut.br_cnt_q = bd_val;
      1: force dut.hit_cnt_q = bd_val;
      default: force dut.mispr_cnt_q = bd_val;
    endcase
    @(negedge clk);
    case (idx)
      0: release dut.br_cnt_q;
      1: release dut.hit_cnt_q;
      default: release dut.mispr_cnt_q;
    endcase
    m_cnt[idx] = v;
  endtask

  logic mon_re, mon_rst;
  exp_t mon_e;
  always @(posedge clk) begin
    mon_re  = mm_re;
    mon_rst = rst;
    #1;
    if (mon_rst || rst) begin
      exp_q.delete();
    end else if (mon_re) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_hit"}, {31'd0, rd_hit}, {31'd0, mon_e.hit});
        chk({mon_e.name, "_data"}, {16'd0, rdata}, {16'd0, mon_e.data});
      end
    end else begin
      chk("idle_rd_hit", {31'd0, rd_hit}, 32'd0);
      chk("idle_rdata", {16'd0, rdata}, 32'd0);
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_rdata", {16'd0, rdata}, 32'd0);
    chk("reset_rd_hit", {31'd0, rd_hit}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int off = 0; off < 8; off++) rd(off, 3'b000);

    // Basic counting: 5 branches, 3 of them also hits.
    wr_ctrl(16'h0001, 3'b000);
    idle(3, 3'b011);
    idle(2, 3'b001);
    rd(1, 3'b000); rd(2, 3'b000); rd(3, 3'b000); rd(5, 3'b000); rd(0, 3'b000);

    // Disabled counting, then clear with a same-cycle strobe.
    wr_ctrl(16'h0002, 3'b000);
    wr_ctrl(16'h0000, 3'b000);
    idle(20, 3'b111);
    rd(1, 3'b000); rd(3, 3'b000); rd(5, 3'b000);
    wr_ctrl(16'h0003, 3'b111);
    rd(0, 3'b000); rd(1, 3'b000); rd(3, 3'b000); rd(5, 3'b000);

    // Snapshot coherence across a carry into the high half.
    set_cnt(0, 32'h0001_FFFF);
    rd(1, 3'b001);
    rd(2, 3'b000);
    rd(1, 3'b000);
    rd(2, 3'b000);

    // Saturation and sticky status.
    set_cnt(2, 32'hFFFF_FFFE);
    idle(3, 3'b100);
    rd(5, 3'b000); rd(6, 3'b000); rd(7, 3'b000);
    wr_ctrl(16'h0003, 3'b000);
    rd(7, 3'b000); rd(5, 3'b000);

    // Out-of-window accesses and ignored writes.
    idle(4, 3'b001);
    drive(1'b1, 1'b0, BASE + 16'd8, 16'h0000, 3'b000);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 3'b000);
    drive(1'b1, 1'b0, BASE - 16'd1, 16'h0000, 3'b000);
    drive(1'b0, 1'b1, BASE + 16'd1, 16'h1234, 3'b000);
    drive(1'b0, 1'b1, BASE + 16'd8, 16'h0002, 3'b000);
    rd(1, 3'b000); rd(2, 3'b000);
    // Simultaneous read and write of CTRL returns the pre-write value.
    drive(1'b1, 1'b1, BASE, 16'h0000, 3'b000);
    drive(1'b1, 1'b1, BASE, 16'h0001, 3'b000);
    rd(0, 3'b000);

    // Randomized traffic, with one counter near saturation.
    set_cnt(1, 32'hFFFF_FFF0);
    for (int i = 0; i < 400; i++) begin
      logic [2:0] inc;
      int op;
      inc = 3'($urandom);
      op  = int'($urandom_range(0, 9));
      if (op <= 4) rd(int'($urandom_range(0, 7)), inc);
      else if (op == 5) wr_ctrl(($urandom_range(0, 15) == 0) ? 16'h0003 : 16'h0001, inc);
      else if (op == 6) drive(1'b1, 1'b1, BASE + 16'($urandom_range(0, 7)), 16'($urandom), inc);
      else if (op == 7) drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                              16'($urandom), 16'($urandom), inc);
      else idle(1, inc);
    end
    for (int off = 0; off < 8; off++) rd(off, 3'b000);

    // Reset while a read is in flight.
    wr_ctrl(16'h0003, 3'b000);
    idle(7, 3'b001);
    rd(1, 3'b000);
    mm_re = 1'b1; addr = BASE + 16'd1;
    model_step();
    #2 rst = 1'b1;
    #1;
    chk("midreset_rdata", {16'd0, rdata}, 32'd0);
    chk("midreset_rd_hit", {31'd0, rd_hit}, 32'd0);
    model_reset();
    exp_q.delete();
    mm_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int off = 0; off < 8; off++) rd(off, 3'b000);
    idle(2, 3'b000);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_perf_counter_mmio.md
Name: bp_perf_counter_mmio

Overview:
- Memory-mapped responder that sits on the CPU data-memory bus (addr/wdata/rdata/mm_we/mm_re).
- Counts the branch-predictor event strobes the CPU emits: inc_br_cnt, inc_hit_cnt and inc_mispr_cnt.
- Software enables, clears and reads the three 32-bit counters through an 8-word register window.
- Register reads return data with a fixed one-cycle latency, muxed into the CPU's rdata path.

Parameters:
- BASE_ADDR, 16'hC000, word address of register window (must be 8-aligned).
- CNT_W, 32, counter width; fixed at 32 (two 16-bit halves).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- addr  input  16  CPU word address
- wdata  input  16  CPU write data
- mm_we  input  1  write strobe, single cycle
- mm_re  input  1  read strobe, single cycle
- inc_br_cnt  input  1  one branch resolved this cycle
- inc_hit_cnt  input  1  one BTB/predictor hit this cycle
- inc_mispr_cnt  input  1  one misprediction this cycle
- rdata  output  16  read data, valid the cycle after mm_re
- rd_hit  output  1  high the cycle after mm_re to a window address; selects this block onto the CPU rdata mux

Behaviour:
- Reset (async, rst=1): all counters, shadows and status are 0; CTRL.en=0; rdata=0; rd_hit=0.
- Window decode: sel = (addr[15:3] == BASE_ADDR[15:3]); off = addr[2:0]. Accesses with sel=0 have no effect, and rdata/rd_hit are 0 next cycle.
- Register map (off):
  - 0 CTRL: bit0 en (R/W). bit1 clear (write-1, self-clearing, reads 0). Other bits read 0.
  - 1 BR_LO, 2 BR_HI.
  - 3 HIT_LO, 4 HIT_HI.
  - 5 MISPR_LO, 6 MISPR_HI.
  - 7 STATUS: bit0 br_sat, bit1 hit_sat, bit2 mispr_sat; sticky; other bits 0.
- Counter rules:
  - A counter increments by 1 on a clk edge where en=1 and its strobe=1.
  - The three counters are independent; any combination of strobes in the same cycle is legal.
  - Counters saturate at 32'hFFFF_FFFF. An increment attempted at max holds the value and sets the matching STATUS sat bit.
- Clear:
  - A write to CTRL with wdata[1]=1 zeroes all three counters, all three shadows and STATUS on that edge.
  - en takes wdata[0] on the same edge.
  - A strobe on the clear cycle is dropped (clear wins).
- Snapshot:
  - A read of X_LO returns counter[15:0] and latches counter[31:16] into shadow_X on the same edge.
  - A read of X_HI returns shadow_X, not the live high half.
  - LO and the captured HI are the same pre-increment value even if a strobe fires in the LO-read cycle.
- Read timing:
  - mm_re & sel in cycle N → rdata = register value sampled at edge N (pre-update), and rd_hit=1, during cycle N+1.
  - With no read, rdata returns to 0 and rd_hit to 0 in the following cycle.
- Writes:
  - Only CTRL is writable. Writes to offsets 1-7 are ignored and do not disturb counters.
- Simultaneous mm_re & mm_we to the same address: write takes effect; read returns the pre-write value.
- Reset mid-operation clears everything immediately, including a pending rdata/rd_hit.

Test Plan:
- Reset, then write CTRL=16'h0001, pulse inc_br_cnt for 5 cycles and inc_hit_cnt for 3 → BR_LO reads 16'h0005, BR_HI 16'h0000, HIT_LO 16'h0003, MISPR_LO 16'h0000, each with rd_hit=1 exactly one cycle after mm_re.
- en=0 with strobes held high for 20 cycles → all counters remain 0; then write CTRL=16'h0003 plus a strobe in the same cycle → counters 0 and en=1 afterwards.
- Force BR to 32'h0001_FFFF via strobes (or bench backdoor), read BR_LO with inc_br_cnt=1 in that cycle → rdata=16'hFFFF; following HI read returns 16'h0001 even though live count is now 32'h0002_0000.
- Counter at 32'hFFFF_FFFF with inc_mispr_cnt=1 → counter stays 32'hFFFF_FFFF; STATUS reads 16'h0004; after CTRL clear, STATUS reads 16'h0000.
- Read at addr=BASE_ADDR+8 and at 16'h0000 → rdata=0, rd_hit=0; write of 16'h1234 to BR_LO → count unchanged.
- Assert rst for 1 cycle while a read is in flight with count 7 → rdata=0, rd_hit=0, en=0, and all counters read 0 afterwards.
